router: RTL and testbench

- Five-port (North, South, East, West, Local) mesh NoC router with 16-bit single-flit packets.
- Per-input FIFO buffering, dimension-ordered XY routing, round-robin output arbitration, credit-based flow control toward neighbours.
- Instantiated once per mesh tile; the Local port connects to the tile's network interface.

---
 rtl/router_pkg.sv | 28 ++
 rtl/router_if.sv | 35 +++
 rtl/router_input_fifo.sv | 57 +++++
 rtl/router.sv | 170 +++++++++++++++++
 tb/tb_router.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the 5-port mesh router.
//   port_e      : port index (N=0, S=1, E=2, W=3, L=4), also the
//                 round-robin order of the output arbiters
//   flit_t      : 16-bit single-flit packet
//   *_LSB/_W    : flit field positions (dest_x[15:13], dest_y[12:10],
//                 payload[9:0])
package router_pkg;

    localparam int NUM_PORTS = 5;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    localparam int FLIT_BITS   = 16;
    localparam int COORD_W     = 3;
    localparam int DEST_X_LSB  = 13;
    localparam int DEST_Y_LSB  = 10;
    localparam int PAYLOAD_LSB = 0;
    localparam int PAYLOAD_W   = 10;

    typedef logic [FLIT_BITS-1:0] flit_t;

endpackage

// File: rtl/router_if.sv
// router_if: flit, valid and credit signals of all five router ports.
//   *_i / valid_*_i / *_incr_i : into the router (flit, valid, credit return
//                                from the downstream neighbour)
//   *_o / valid_*_o / *_incr_o : out of the router (flit, valid, credit return
//                                to the upstream sender)
//   modport slave  : router side
//   modport master : tile / neighbour side
interface router_if #(
    parameter int FLIT_W = 16
);
    logic [FLIT_W-1:0] north_i, south_i, east_i, west_i, local_i;
    logic              valid_n_i, valid_s_i, valid_e_i, valid_w_i, valid_l_i;
    logic              n_incr_i, s_incr_i, e_incr_i, w_incr_i, l_incr_i;
    logic [FLIT_W-1:0] north_o, south_o, east_o, west_o, local_o;
    logic              valid_n_o, valid_s_o, valid_e_o, valid_w_o, valid_l_o;
    logic              n_incr_o, s_incr_o, e_incr_o, w_incr_o, l_incr_o;

    modport slave (
        input  north_i, south_i, east_i, west_i, local_i,
        input  valid_n_i, valid_s_i, valid_e_i, valid_w_i, valid_l_i,
        input  n_incr_i, s_incr_i, e_incr_i, w_incr_i, l_incr_i,
        output north_o, south_o, east_o, west_o, local_o,
        output valid_n_o, valid_s_o, valid_e_o, valid_w_o, valid_l_o,
        output n_incr_o, s_incr_o, e_incr_o, w_incr_o, l_incr_o
    );

    modport master (
        output north_i, south_i, east_i, west_i, local_i,
        output valid_n_i, valid_s_i, valid_e_i, valid_w_i, valid_l_i,
        output n_incr_i, s_incr_i, e_incr_i, w_incr_i, l_incr_i,
        input  north_o, south_o, east_o, west_o, local_o,
        input  valid_n_o, valid_s_o, valid_e_o, valid_w_o, valid_l_o,
        input  n_incr_o, s_incr_o, e_incr_o, w_incr_o, l_incr_o
    );
endinterface

// File: rtl/router_input_fifo.sv
// router_input_fifo: per-input flit buffer with show-ahead head.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write din when not full; a push while full is dropped
//   pop      : remove the head entry when not empty
//   full, empty, head : status and current head entry
module router_input_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/router.sv
// router: 5-port mesh NoC router (N, S, E, W, Local), single-flit packets.
//   clk, rst : clock, synchronous active-high reset
//   bus      : router_if.slave carrying per-port flit/valid inputs, credit
//              returns from neighbours, registered flit/valid outputs and
//              credit returns to upstream senders
// Input FIFOs feed XY routing on each head; each output grants one requester
// per cycle round-robin (N,S,E,W,L) when it holds a credit. Output flits and
// credit returns are registered, so an uncontended flit leaves two cycles
// after it is written.
// Optional: define ROUTER_ASSERT_EN for simulation checks on FIFO overflow,
// credit over-return and routes back to the arrival port.
module router
    import router_pkg::*;
#(
    parameter int FLIT_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int X_ID      = 1,
    parameter int Y_ID      = 1,
    parameter int BUF_DEPTH = 4
) (
    input logic      clk,
    input logic      rst,
    router_if.slave  bus
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [ADDR_W-1:0] MY_X = ADDR_W'(X_ID);
    localparam logic [ADDR_W-1:0] MY_Y = ADDR_W'(Y_ID);

    logic [FLIT_W-1:0]    in_flit  [NUM_PORTS];
    logic [FLIT_W-1:0]    head     [NUM_PORTS];
    logic [NUM_PORTS-1:0] in_valid, in_incr, full, empty, pop;

    port_e                route    [NUM_PORTS];
    logic [NUM_PORTS-1:0] req      [NUM_PORTS];   // req[out][in]
    logic [NUM_PORTS-1:0] gnt      [NUM_PORTS];   // gnt[out][in]
    port_e                winner   [NUM_PORTS];
    logic [NUM_PORTS-1:0] send;

    logic [CW-1:0]        credit   [NUM_PORTS];
    port_e                ptr      [NUM_PORTS];
    logic [FLIT_W-1:0]    out_flit [NUM_PORTS];
    logic [NUM_PORTS-1:0] out_valid, incr_out;

    assign in_flit[PORT_N] = bus.north_i;
    assign in_flit[PORT_S] = bus.south_i;
    assign in_flit[PORT_E] = bus.east_i;
    assign in_flit[PORT_W] = bus.west_i;
    assign in_flit[PORT_L] = bus.local_i;
    assign in_valid = {bus.valid_l_i, bus.valid_w_i, bus.valid_e_i, bus.valid_s_i, bus.valid_n_i};
    assign in_incr  = {bus.l_incr_i, bus.w_incr_i, bus.e_incr_i, bus.s_incr_i, bus.n_incr_i};

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
        router_input_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_valid[i] && !full[i]),
            .pop   (pop[i]),
            .din   (in_flit[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    // XY routing on every head, then one-hot request per output.
    always_comb begin
        logic [ADDR_W-1:0] dx, dy;
        dx = '0;
        dy = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) req[o] = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            dx = head[i][DEST_X_LSB +: ADDR_W];
            dy = head[i][DEST_Y_LSB +: ADDR_W];
            if (dx > MY_X)      route[i] = PORT_E;
            else if (dx < MY_X) route[i] = PORT_W;
            else if (dy > MY_Y) route[i] = PORT_N;
            else if (dy < MY_Y) route[i] = PORT_S;
            else                route[i] = PORT_L;
            if (!empty[i]) req[route[i]][i] = 1'b1;
        end
    end

    // Round-robin search starting at each output's pointer; only outputs
    // holding a credit may grant.
    always_comb begin
        int unsigned idx;
        idx = 0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            gnt[o]    = '0;
            winner[o] = PORT_N;
            send[o]   = 1'b0;
            if (credit[o] != '0) begin
                for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                    idx = int'(ptr[o]) + k;
                    if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                    if (!send[o] && req[o][idx]) begin
                        send[o]     = 1'b1;
                        gnt[o][idx] = 1'b1;
                        winner[o]   = port_e'(idx);
                    end
                end
            end
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            pop[i] = 1'b0;
            for (int unsigned o = 0; o < NUM_PORTS; o++) pop[i] = pop[i] | gnt[o][i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            incr_out  <= '0;
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                out_flit[o] <= '0;
                credit[o]   <= CW'(BUF_DEPTH);
                ptr[o]      <= PORT_N;
            end
        end else begin
            out_valid <= send;
            incr_out  <= pop;
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                if (send[o]) begin
                    out_flit[o] <= head[winner[o]];
                    ptr[o]      <= (winner[o] == PORT_L) ? PORT_N : port_e'(winner[o] + 3'd1);
                end
                // Send and return in the same cycle cancel; returns saturate.
                case ({send[o], in_incr[o]})
                    2'b10:   credit[o] <= credit[o] - 1'b1;
                    2'b01:   if (credit[o] != CW'(BUF_DEPTH)) credit[o] <= credit[o] + 1'b1;
                    default: credit[o] <= credit[o];
                endcase
            end
        end
    end

`ifdef ROUTER_ASSERT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                assert (!(in_valid[i] && full[i]))
                    else $error("router: write to full FIFO on port %0d", i);
                assert (!(in_incr[i] && credit[i] == CW'(BUF_DEPTH)))
                    else $error("router: credit return at full credit on port %0d", i);
                assert (!(!empty[i] && route[i] == port_e'(i)))
                    else $error("router: route back to arrival port %0d", i);
            end
        end
    end
`endif

    assign bus.north_o   = out_flit[PORT_N];
    assign bus.south_o   = out_flit[PORT_S];
    assign bus.east_o    = out_flit[PORT_E];
    assign bus.west_o    = out_flit[PORT_W];
    assign bus.local_o   = out_flit[PORT_L];
    assign bus.valid_n_o = out_valid[PORT_N];
    assign bus.valid_s_o = out_valid[PORT_S];
    assign bus.valid_e_o = out_valid[PORT_E];
    assign bus.valid_w_o = out_valid[PORT_W];
    assign bus.valid_l_o = out_valid[PORT_L];
    assign bus.n_incr_o  = incr_out[PORT_N];
    assign bus.s_incr_o  = incr_out[PORT_S];
    assign bus.e_incr_o  = incr_out[PORT_E];
    assign bus.w_incr_o  = incr_out[PORT_W];
    assign bus.l_incr_o  = incr_out[PORT_L];
endmodule

// File: tb/tb_router.sv
// tb_router: directed self-checking bench for router (X_ID=1, Y_ID=1,
// BUF_DEPTH=4). Routing, contention, credits, overflow and mid-traffic reset.
module tb_router;
    import router_pkg::*;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   out_cnt [NUM_PORTS];
    logic [15:0] east_q [$];

    router_if #(.FLIT_W(16)) bus ();

    router #(
        .FLIT_W    (16),
        .ADDR_W    (3),
        .X_ID      (1),
        .Y_ID      (1),
        .BUF_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic flit_t make_flit(input logic [2:0] x, input logic [2:0] y,
                                        input logic [9:0] p);
        flit_t f;
        f = '0;
        f[DEST_X_LSB +: COORD_W]    = x;
        f[DEST_Y_LSB +: COORD_W]    = y;
        f[PAYLOAD_LSB +: PAYLOAD_W] = p;
        return f;
    endfunction

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.valid_n_o) out_cnt[PORT_N]++;
        if (bus.valid_s_o) out_cnt[PORT_S]++;
        if (bus.valid_e_o) out_cnt[PORT_E]++;
        if (bus.valid_w_o) out_cnt[PORT_W]++;
        if (bus.valid_l_o) out_cnt[PORT_L]++;
        if (bus.valid_e_o) east_q.push_back(bus.east_o);
    endtask

    task automatic clear_mon();
        foreach (out_cnt[i]) out_cnt[i] = 0;
        east_q.delete();
    endtask

    task automatic idle();
        bus.valid_n_i = 1'b0; bus.valid_s_i = 1'b0; bus.valid_e_i = 1'b0;
        bus.valid_w_i = 1'b0; bus.valid_l_i = 1'b0;
        bus.n_incr_i  = 1'b0; bus.s_incr_i  = 1'b0; bus.e_incr_i  = 1'b0;
        bus.w_incr_i  = 1'b0; bus.l_incr_i  = 1'b0;
    endtask

    task automatic send(input port_e p, input logic [15:0] f);
        case (p)
            PORT_N:  begin bus.north_i = f; bus.valid_n_i = 1'b1; end
            PORT_S:  begin bus.south_i = f; bus.valid_s_i = 1'b1; end
            PORT_E:  begin bus.east_i  = f; bus.valid_e_i = 1'b1; end
            PORT_W:  begin bus.west_i  = f; bus.valid_w_i = 1'b1; end
            default: begin bus.local_i = f; bus.valid_l_i = 1'b1; end
        endcase
    endtask

    task automatic reset_dut();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic chk_all_zero(input string tag);
        chk16({tag, "_north_o"}, bus.north_o, 16'h0000);
        chk16({tag, "_south_o"}, bus.south_o, 16'h0000);
        chk16({tag, "_east_o"},  bus.east_o,  16'h0000);
        chk16({tag, "_west_o"},  bus.west_o,  16'h0000);
        chk16({tag, "_local_o"}, bus.local_o, 16'h0000);
        chk16({tag, "_valids"}, {11'b0, bus.valid_n_o, bus.valid_s_o, bus.valid_e_o,
                                 bus.valid_w_o, bus.valid_l_o}, 16'h0000);
        chk16({tag, "_incrs"},  {11'b0, bus.n_incr_o, bus.s_incr_o, bus.e_incr_o,
                                 bus.w_incr_o, bus.l_incr_o}, 16'h0000);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.north_i = '0; bus.south_i = '0; bus.east_i = '0;
        bus.west_i  = '0; bus.local_i = '0;
        idle();
        clear_mon();

        // Reset state
        step();
        reset_dut();
        chk_all_zero("rst");

        // Routing: local 4455 (dest 2,1) -> East at c+2 with l_incr_o
        send(PORT_L, 16'h4455); step(); idle();
        chk1("r1_not_early", bus.valid_e_o, 1'b0);
        step();
        chk16("r1_east_o", bus.east_o, 16'h4455);
        chk1("r1_valid_e", bus.valid_e_o, 1'b1);
        chk1("r1_l_incr", bus.l_incr_o, 1'b1);
        step();
        chk1("r1_valid_e_drop", bus.valid_e_o, 1'b0);
        chk1("r1_l_incr_drop", bus.l_incr_o, 1'b0);
        chk16("r1_east_hold", bus.east_o, 16'h4455);

        // North 24AB (dest 1,1) -> Local
        send(PORT_N, 16'h24AB); step(); idle(); step();
        chk16("r2_local_o", bus.local_o, 16'h24AB);
        chk1("r2_valid_l", bus.valid_l_o, 1'b1);
        chk1("r2_n_incr", bus.n_incr_o, 1'b1);
        step();

        // Local 2C00 (dest 1,3) -> North
        send(PORT_L, 16'h2C00); step(); idle(); step();
        chk16("r3_north_o", bus.north_o, 16'h2C00);
        chk1("r3_valid_n", bus.valid_n_o, 1'b1);
        step();

        // Local 0C12 (dest 0,3) -> West, X first
        send(PORT_L, 16'h0C12); step(); idle(); step();
        chk16("r4_west_o", bus.west_o, 16'h0C12);
        chk1("r4_valid_w", bus.valid_w_o, 1'b1);
        chk1("r4_valid_n", bus.valid_n_o, 1'b0);
        step();

        // Contention: N and S both to Local; N wins first after reset
        reset_dut();
        send(PORT_N, 16'h2401);
        send(PORT_S, 16'h2402);
        step(); idle(); step();
        chk16("ct_first", bus.local_o, 16'h2401);
        chk1("ct_first_v", bus.valid_l_o, 1'b1);
        chk1("ct_first_n_incr", bus.n_incr_o, 1'b1);
        chk1("ct_first_s_incr", bus.s_incr_o, 1'b0);
        step();
        chk16("ct_second", bus.local_o, 16'h2402);
        chk1("ct_second_v", bus.valid_l_o, 1'b1);
        chk1("ct_second_s_incr", bus.s_incr_o, 1'b1);
        chk1("ct_second_n_incr", bus.n_incr_o, 1'b0);
        step();
        chk1("ct_done_v", bus.valid_l_o, 1'b0);

        // Credits: 5 flits to East with no returns -> 4 leave, 5th stalls
        reset_dut();
        for (int k = 1; k <= 5; k++) begin
            send(PORT_L, make_flit(3'd2, 3'd0, 10'(k)));
            step();
        end
        idle();
        repeat (10) step();
        chk16("cr_count", 16'(east_q.size()), 16'd4);
        for (int k = 0; k < east_q.size(); k++)
            chk16("cr_flit", east_q[k], 16'h4000 + 16'(k + 1));
        east_q.delete();
        bus.e_incr_i = 1'b1; step(); bus.e_incr_i = 1'b0;
        for (int k = 0; k < 2 && east_q.size() == 0; k++) step();
        chk16("cr_fifth_count", 16'(east_q.size()), 16'd1);
        if (east_q.size() > 0) chk16("cr_fifth", east_q[0], 16'h4005);

        // Overflow: East credits exhausted, 5 writes to West -> 4 retained
        reset_dut();
        for (int k = 1; k <= 4; k++) begin
            send(PORT_L, make_flit(3'd2, 3'd1, 10'h30 + 10'(k)));
            step();
        end
        idle();
        repeat (6) step();
        chk16("of_drain", 16'(east_q.size()), 16'd4);
        east_q.delete();
        for (int k = 1; k <= 5; k++) begin
            send(PORT_W, make_flit(3'd2, 3'd2, 10'h40 + 10'(k)));
            step();
        end
        idle();
        repeat (4) step();
        chk16("of_blocked", 16'(east_q.size()), 16'd0);
        for (int k = 0; k < 5; k++) begin
            bus.e_incr_i = 1'b1;
            step();
        end
        bus.e_incr_i = 1'b0;
        repeat (6) step();
        chk16("of_count", 16'(east_q.size()), 16'd4);
        for (int k = 0; k < east_q.size(); k++)
            chk16("of_flit", east_q[k], 16'h4840 + 16'(k + 1));

        // Reset mid-traffic with Local and West FIFOs holding stalled flits
        reset_dut();
        for (int k = 1; k <= 6; k++) begin
            send(PORT_L, make_flit(3'd2, 3'd0, 10'h50 + 10'(k)));
            if (k <= 2) send(PORT_W, make_flit(3'd3, 3'd0, 10'h60 + 10'(k)));
            step();
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("mid_rst");
        clear_mon();
        repeat (8) step();
        for (int p = 0; p < NUM_PORTS; p++)
            chk16("stale_cnt", 16'(out_cnt[p]), 16'd0);
        clear_mon();
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0:       send(PORT_L, make_flit(3'd2, 3'd1, 10'(i)));
                1:       send(PORT_L, make_flit(3'd1, 3'd2, 10'(i)));
                2:       send(PORT_L, make_flit(3'd1, 3'd0, 10'(i)));
                default: send(PORT_L, make_flit(3'd0, 3'd1, 10'(i)));
            endcase
            if (i < 4) send(PORT_N, make_flit(3'd1, 3'd1, 10'(i)));
            else       bus.valid_n_i = 1'b0;
            step();
        end
        idle();
        repeat (10) step();
        chk16("fresh_n", 16'(out_cnt[PORT_N]), 16'd4);
        chk16("fresh_s", 16'(out_cnt[PORT_S]), 16'd4);
        chk16("fresh_e", 16'(out_cnt[PORT_E]), 16'd4);
        chk16("fresh_w", 16'(out_cnt[PORT_W]), 16'd4);
        chk16("fresh_l", 16'(out_cnt[PORT_L]), 16'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
